// File: rtl/apb_requester_pkg.sv
// Shared types and constants for the APB requester.
package apb_requester_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESPONSE
   } apb_requester_state_e;

   localparam logic [2:0] APB_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/apb_requester.sv
// APB initiator: turns single valid/ready commands into APB SETUP/ACCESS transfers.
// Optional ACCESS-phase timeout is compiled in with APB_REQUESTER_TIMEOUT_EN.
module apb_requester
   import apb_requester_pkg::*;
#(
   parameter int ADDRESS_WIDTH  = 7,
   parameter int BUS_WIDTH      = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_cmd_valid,
   output logic                     o_cmd_ready,
   input  logic                     i_cmd_write,
   input  logic [ADDRESS_WIDTH-1:0] i_cmd_address,
   input  logic [BUS_WIDTH-1:0]     i_cmd_write_data,
   input  logic [BUS_WIDTH/8-1:0]   i_cmd_strobe,
   output logic                     o_rsp_valid,
   input  logic                     i_rsp_ready,
   output logic [BUS_WIDTH-1:0]     o_rsp_read_data,
   output logic                     o_rsp_error,
   output logic                     o_psel,
   output logic                     o_penable,
   output logic                     o_pwrite,
   output logic [ADDRESS_WIDTH-1:0] o_paddr,
   output logic [2:0]               o_pprot,
   output logic [BUS_WIDTH-1:0]     o_pwdata,
   output logic [BUS_WIDTH/8-1:0]   o_pstrb,
   input  logic                     i_pready,
   input  logic                     i_pslverr,
   input  logic [BUS_WIDTH-1:0]     i_prdata
);

   apb_requester_state_e state_q, state_d;

   logic                     pwrite_q;
   logic [ADDRESS_WIDTH-1:0] paddr_q;
   logic [BUS_WIDTH-1:0]     pwdata_q;
   logic [BUS_WIDTH/8-1:0]   pstrb_q;
   logic [BUS_WIDTH-1:0]     rsp_rdata_q;
   logic                     rsp_error_q;

   logic cmd_fire;
   logic access_end;
   logic timeout_hit;

   assign cmd_fire   = i_cmd_valid && (state_q == IDLE);
   assign access_end = (state_q == ACCESS) && (i_pready || timeout_hit);

`ifdef APB_REQUESTER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] tmo_cnt_q;

   // Limit is reached on the TIMEOUT_CYCLES-th stalled ACCESS cycle; pready on that cycle still wins.
   assign timeout_hit = (state_q == ACCESS) && !i_pready &&
                        (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         tmo_cnt_q <= '0;
      end else if (state_q == SETUP) begin
         tmo_cnt_q <= '0;
      end else if ((state_q == ACCESS) && !i_pready) begin
         tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
   end
`else
   logic unused_timeout_cfg;

   assign timeout_hit        = 1'b0;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (i_cmd_valid) state_d = SETUP;
         SETUP:    state_d = ACCESS;
         ACCESS:   if (i_pready || timeout_hit) state_d = RESPONSE;
         RESPONSE: if (i_rsp_ready) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      o_cmd_ready = 1'b0;
      o_psel      = 1'b0;
      o_penable   = 1'b0;
      o_rsp_valid = 1'b0;
      case (state_q)
         IDLE:     o_cmd_ready = 1'b1;
         SETUP:    o_psel      = 1'b1;
         ACCESS: begin
            o_psel    = 1'b1;
            o_penable = 1'b1;
         end
         RESPONSE: o_rsp_valid = 1'b1;
         default:  o_cmd_ready = 1'b0;
      endcase
   end

   // Write data and strobes are zeroed for reads so PWDATA/PSTRB never carry stale values.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         pstrb_q     <= '0;
         rsp_rdata_q <= '0;
         rsp_error_q <= 1'b0;
      end else begin
         if (cmd_fire) begin
            pwrite_q <= i_cmd_write;
            paddr_q  <= i_cmd_address;
            pwdata_q <= i_cmd_write ? i_cmd_write_data : '0;
            pstrb_q  <= i_cmd_write ? i_cmd_strobe : '0;
         end
         if (access_end) begin
            rsp_rdata_q <= (i_pready && !pwrite_q) ? i_prdata : '0;
            rsp_error_q <= i_pready ? i_pslverr : 1'b1;
         end
      end
   end

   assign o_pwrite        = pwrite_q;
   assign o_paddr         = paddr_q;
   assign o_pwdata        = pwdata_q;
   assign o_pstrb         = pstrb_q;
   assign o_pprot         = APB_PROT_DEFAULT;
   assign o_rsp_read_data = rsp_rdata_q;
   assign o_rsp_error     = rsp_error_q;

endmodule

// File: tb/tb_apb_requester.sv
// Self-checking bench for apb_requester; exercises the timeout path when APB_REQUESTER_TIMEOUT_EN is defined.
module tb_apb_requester;

   localparam int AW  = 7;
   localparam int DW  = 32;
   localparam int SW  = DW / 8;
   localparam int TMO = 8;
`ifdef APB_REQUESTER_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_write = 1'b0;
   logic [AW-1:0] cmd_address = '0;
   logic [DW-1:0] cmd_write_data = '0;
   logic [SW-1:0] cmd_strobe = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rsp_read_data;
   logic          rsp_error;
   logic          psel, penable, pwrite;
   logic [AW-1:0] paddr;
   logic [2:0]    pprot;
   logic [DW-1:0] pwdata;
   logic [SW-1:0] pstrb;
   logic          pready = 1'b0;
   logic          pslverr = 1'b0;
   logic [DW-1:0] prdata = '0;

   int checks = 0;
   int errors = 0;

   apb_requester #(
      .ADDRESS_WIDTH (AW),
      .BUS_WIDTH     (DW),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_cmd_valid     (cmd_valid),
      .o_cmd_ready     (cmd_ready),
      .i_cmd_write     (cmd_write),
      .i_cmd_address   (cmd_address),
      .i_cmd_write_data(cmd_write_data),
      .i_cmd_strobe    (cmd_strobe),
      .o_rsp_valid     (rsp_valid),
      .i_rsp_ready     (rsp_ready),
      .o_rsp_read_data (rsp_read_data),
      .o_rsp_error     (rsp_error),
      .o_psel          (psel),
      .o_penable       (penable),
      .o_pwrite        (pwrite),
      .o_paddr         (paddr),
      .o_pprot         (pprot),
      .o_pwdata        (pwdata),
      .o_pstrb         (pstrb),
      .i_pready        (pready),
      .i_pslverr       (pslverr),
      .i_prdata        (prdata)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit exceeded");
      $fatal(1, "watchdog");
   end

   // Transaction-level model: the expected bus/response behaviour comes from the command,
   // the number of wait states the slave inserts and the timeout rule.
   task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [SW-1:0] strb, input int waits, input logic [DW-1:0] rdata,
                          input bit slverr, input int rsp_delay, input bit presented,
                          input bit chain, input bit n_wr, input logic [AW-1:0] n_addr,
                          input logic [DW-1:0] n_wdata, input logic [SW-1:0] n_strb);
      bit            to;
      int            acc;
      logic [DW-1:0] exp_rd;
      bit            exp_err;
      logic [47:0]   got_bus, exp_bus;
      logic [36:0]   got_rsp, exp_rsp;
      to      = TO_EN && (waits >= TMO);
      acc     = to ? TMO : waits + 1;
      exp_rd  = (to || wr) ? '0 : rdata;
      exp_err = to ? 1'b1 : slverr;
      exp_bus = {1'b1, 1'b0, wr, addr, (wr ? wdata : {DW{1'b0}}), (wr ? strb : {SW{1'b0}}), 1'b0, 1'b0};
      exp_rsp = {1'b1, exp_err, exp_rd, 1'b0, 1'b0, 1'b0};

      if (!presented) begin
         @(negedge clk);
         cmd_valid = 1'b1; cmd_write = wr; cmd_address = addr;
         cmd_write_data = wdata; cmd_strobe = strb;
      end
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++; $display("FAIL accept_ready got %b expected 1", cmd_ready);
      end
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0; cmd_write = $urandom; cmd_address = AW'($urandom);
      cmd_write_data = $urandom; cmd_strobe = SW'($urandom);
      got_bus = {psel, penable, pwrite, paddr, pwdata, pstrb, cmd_ready, rsp_valid};
      checks++;
      if (got_bus !== exp_bus) begin
         errors++; $display("FAIL setup_phase got %h expected %h", got_bus, exp_bus);
      end
      pready = $urandom; pslverr = $urandom; prdata = $urandom;
      exp_bus[46] = 1'b1;
      for (int k = 0; k < acc; k++) begin
         @(negedge clk);
         got_bus = {psel, penable, pwrite, paddr, pwdata, pstrb, cmd_ready, rsp_valid};
         checks++;
         if (got_bus !== exp_bus) begin
            errors++; $display("FAIL access_cycle%0d got %h expected %h", k, got_bus, exp_bus);
         end
         if (!to && k == waits) begin
            pready = 1'b1; pslverr = slverr; prdata = rdata;
         end else begin
            pready = 1'b0; pslverr = $urandom; prdata = $urandom;
         end
      end
      @(negedge clk);
      pready = $urandom; pslverr = $urandom; prdata = $urandom;
      got_rsp = {rsp_valid, rsp_error, rsp_read_data, psel, penable, cmd_ready};
      checks++;
      if (got_rsp !== exp_rsp) begin
         errors++; $display("FAIL response got %h expected %h", got_rsp, exp_rsp);
      end
      if (chain) begin
         cmd_valid = 1'b1; cmd_write = n_wr; cmd_address = n_addr;
         cmd_write_data = n_wdata; cmd_strobe = n_strb;
      end
      for (int d = 0; d < rsp_delay; d++) begin
         @(negedge clk);
         pready = $urandom; pslverr = $urandom; prdata = $urandom;
         got_rsp = {rsp_valid, rsp_error, rsp_read_data, psel, penable, cmd_ready};
         checks++;
         if (got_rsp !== exp_rsp) begin
            errors++; $display("FAIL response_hold%0d got %h expected %h", d, got_rsp, exp_rsp);
         end
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      got_rsp = {rsp_valid, 1'b0, {DW{1'b0}}, psel, penable, cmd_ready};
      checks++;
      if (got_rsp !== 37'h1) begin
         errors++; $display("FAIL after_handshake got %h expected %h", got_rsp, 37'h1);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({cmd_ready, rsp_valid, psel, penable, pwrite, rsp_error} !== 6'b100000) begin
         errors++; $display("FAIL reset_ctl got %b expected 100000",
                            {cmd_ready, rsp_valid, psel, penable, pwrite, rsp_error});
      end
      checks++;
      if ({paddr, pwdata, pstrb, rsp_read_data, pprot} !== '0) begin
         errors++; $display("FAIL reset_data got %h expected 0",
                            {paddr, pwdata, pstrb, rsp_read_data, pprot});
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({cmd_ready, psel, rsp_valid} !== 3'b100) begin
         errors++; $display("FAIL idle_after_reset got %b expected 100", {cmd_ready, psel, rsp_valid});
      end
   endtask

   task automatic test_write_basic();
      run_txn(1'b1, 7'h04, 32'h0000_00A5, 4'b0001, 0, 32'hDEAD_BEEF, 1'b0, 0,
              1'b0, 1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic test_read_wait_states();
      run_txn(1'b0, 7'h10, 32'h1234_5678, 4'b1111, 3, 32'h0000_003C, 1'b0, 0,
              1'b0, 1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic test_slverr_hold();
      run_txn(1'b0, 7'h20, '0, '0, 1, 32'h0BAD_F00D, 1'b1, 5,
              1'b0, 1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic test_back_to_back();
      run_txn(1'b1, 7'h30, 32'hCAFE_0001, 4'b1100, 0, '0, 1'b0, 3,
              1'b0, 1'b1, 1'b0, 7'h44, 32'hFFFF_FFFF, 4'b1111);
      run_txn(1'b0, 7'h44, 32'hFFFF_FFFF, 4'b1111, 0, 32'h5A5A_A5A5, 1'b0, 0,
              1'b1, 1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic test_reset_mid_access();
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 7'h55;
      cmd_write_data = 32'h1111_2222; cmd_strobe = 4'b1010;
      @(negedge clk);
      cmd_valid = 1'b0; pready = 1'b0;
      @(negedge clk);
      checks++;
      if ({psel, penable} !== 2'b11) begin
         errors++; $display("FAIL pre_reset_access got %b expected 11", {psel, penable});
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({psel, penable, rsp_valid, cmd_ready, pwrite} !== 5'b00010) begin
         errors++; $display("FAIL async_reset_ctl got %b expected 00010",
                            {psel, penable, rsp_valid, cmd_ready, pwrite});
      end
      checks++;
      if ({paddr, pwdata, pstrb} !== '0) begin
         errors++; $display("FAIL async_reset_data got %h expected 0", {paddr, pwdata, pstrb});
      end
      pready = 1'b1; prdata = 32'hFFFF_0000;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if ({rsp_valid, psel, cmd_ready} !== 3'b001) begin
            errors++; $display("FAIL no_stale_rsp%0d got %b expected 001", i, {rsp_valid, psel, cmd_ready});
         end
      end
      pready = 1'b0;
   endtask

   task automatic test_long_wait();
      // Timeout build: 20 stalls aborts after TMO cycles; 7 stalls completes on the last allowed cycle.
      run_txn(1'b0, 7'h08, '0, '0, 20, 32'h7777_8888, 1'b0, 1,
              1'b0, 1'b0, 1'b0, '0, '0, '0);
      run_txn(1'b0, 7'h0C, '0, '0, TMO - 1, 32'h0000_1357, 1'b0, 0,
              1'b0, 1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic test_random();
      int max_waits;
      max_waits = TO_EN ? 10 : 5;
      for (int i = 0; i < 16; i++) begin
         run_txn(1'($urandom), AW'($urandom), $urandom, SW'($urandom),
                 int'($urandom_range(max_waits, 0)), $urandom, 1'($urandom),
                 int'($urandom_range(3, 0)), 1'b0, 1'b0, 1'b0, '0, '0, '0);
      end
   endtask

   initial begin
      test_reset();
      test_write_basic();
      test_read_wait_states();
      test_slverr_hold();
      test_back_to_back();
      test_reset_mid_access();
      test_long_wait();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
